// File: rtl/vpu_h2d_req_issuer.sv
// Host-to-device request issuer: packs host instruction fields into one
// request word, holds it in a small issue FIFO and sends it to the VPU
// request FIFO over valid/ready. Sends are gated by credits, where each
// credit is one free VPU request-FIFO slot.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   host_valid_i/ready_o    host handshake
//   host_opcode_i, host_dst0_i, host_src0_i, host_src1_i, host_src2_i,
//   host_imm_i              instruction fields
//   req_valid_o/ready_i     VPU handshake
//   req_instr_o             packed request word (0 when the buffer is empty)
//   credit_return_i         one-cycle pulse, one VPU FIFO slot freed
//   credit_cnt_o            current credit count
//   err_clr_i               clears the sticky error flags
//   err_illegal_op_o        sticky: an illegal opcode was dropped
//   err_credit_ovf_o        sticky: a credit was returned while already full
//   idle_o                  buffer empty and all credits home
module vpu_h2d_req_issuer #(
   parameter int unsigned ADDR_WIDTH  = 24,
   parameter int unsigned INSTR_WIDTH = 128,   // must equal 8 + 5*ADDR_WIDTH
   parameter int unsigned BUF_DEPTH   = 4,     // power of 2, >= 2
   parameter int unsigned CREDIT_MAX  = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               host_valid_i,
   output logic                               host_ready_o,
   input  logic [7:0]                         host_opcode_i,
   input  logic [ADDR_WIDTH-1:0]              host_dst0_i,
   input  logic [ADDR_WIDTH-1:0]              host_src0_i,
   input  logic [ADDR_WIDTH-1:0]              host_src1_i,
   input  logic [ADDR_WIDTH-1:0]              host_src2_i,
   input  logic [ADDR_WIDTH-1:0]              host_imm_i,
   output logic                               req_valid_o,
   input  logic                               req_ready_i,
   output logic [INSTR_WIDTH-1:0]             req_instr_o,
   input  logic                               credit_return_i,
   output logic [$clog2(CREDIT_MAX+1)-1:0]    credit_cnt_o,
   input  logic                               err_clr_i,
   output logic                               err_illegal_op_o,
   output logic                               err_credit_ovf_o,
   output logic                               idle_o
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned CRD_W = $clog2(CREDIT_MAX + 1);
   localparam int unsigned PKT_W = 8 + 5 * ADDR_WIDTH;

   localparam logic [7:0] OP_MIN = 8'h01;
   localparam logic [7:0] OP_MAX = 8'h0E;

   logic [INSTR_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [CNT_W-1:0]       count_q;
   logic [CRD_W-1:0]       credit_q;
   logic                   out_of_rst_q;
   logic                   err_ill_q;
   logic                   err_ovf_q;

   logic                   buf_full;
   logic                   buf_empty;
   logic                   credit_at_max;
   logic                   host_fire;
   logic                   op_legal;
   logic                   push;
   logic                   illegal_evt;
   logic                   send;
   logic                   ovf_evt;
   logic [PKT_W-1:0]       packed_word;

   // Handshake and event decode; everything here depends on registered state
   // plus the current inputs, never on a path back into host_ready_o.
   always_comb begin
      buf_full      = (count_q == CNT_W'(BUF_DEPTH));
      buf_empty     = (count_q == '0);
      credit_at_max = (credit_q == CRD_W'(CREDIT_MAX));
      host_ready_o  = out_of_rst_q & ~buf_full;
      host_fire     = host_valid_i & host_ready_o;
      op_legal      = (host_opcode_i >= OP_MIN) && (host_opcode_i <= OP_MAX);
      push          = host_fire & op_legal;
      illegal_evt   = host_fire & ~op_legal;
      req_valid_o   = ~buf_empty & (credit_q != '0);
      send          = req_valid_o & req_ready_i;
      ovf_evt       = credit_return_i & ~send & credit_at_max;
      req_instr_o   = buf_empty ? '0 : mem[rd_ptr_q];
      credit_cnt_o  = credit_q;
      err_illegal_op_o = err_ill_q;
      err_credit_ovf_o = err_ovf_q;
      idle_o        = buf_empty & credit_at_max;
      packed_word   = {host_opcode_i, host_dst0_i, host_src0_i,
                       host_src1_i, host_src2_i, host_imm_i};
   end

   // Issue-buffer storage; contents are don't-care while the slot is free.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= INSTR_WIDTH'(packed_word);
      end
   end

   // Buffer pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_of_rst_q <= 1'b0;
      end else begin
         out_of_rst_q <= 1'b1;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (send) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, send})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Credit counter; a return and a send in the same cycle cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q <= CRD_W'(CREDIT_MAX);
      end else if (send && !credit_return_i) begin
         credit_q <= credit_q - CRD_W'(1);
      end else if (credit_return_i && !send && !credit_at_max) begin
         credit_q <= credit_q + CRD_W'(1);
      end
   end

   // Sticky errors; a new event outranks a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ill_q <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         err_ill_q <= illegal_evt | (err_ill_q & ~err_clr_i);
         err_ovf_q <= ovf_evt | (err_ovf_q & ~err_clr_i);
      end
   end

endmodule
